memory_access_stage: RTL
========================

// Module: memory_access_stage
// PURPOSE
//  Memory (M) stage of the 18-bit pipeline; consumes the M-side outputs of the execute stage.
//  Performs loads/stores over a req/ack data-memory bus, including 6-bit RGB channel accesses
//  (channel stores use read-modify-write). Raises StallM to the hazard unit while an access
//  is outstanding, then registers results into the writeback (W) stage.
// PARAMETERS
//  ADDR_W          10   data-memory word address width; mem_addr = ALU_ResultM[ADDR_W-1:0]
//  TIMEOUT_CYCLES  255  wait cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       synchronous, active-high reset
//  RegWriteM    in   1       register write enable of the M instruction
//  MemWriteM    in   1       store
//  ResultSrcM   in   1       load (1) / ALU result (0)
//  RD_M         in   5       destination register
//  PCPlus4M     in   18      link value, passed through
//  ALU_ResultM  in   18      address / ALU result
//  WriteDataM   in   18      store data
//  RGB_M        in   2       00 full word; 01 bits[5:0]; 10 bits[11:6]; 11 bits[17:12]
//  mem_req      out  1       bus request
//  mem_we       out  1       1 = write
//  mem_addr     out  ADDR_W  word address
//  mem_wdata    out  18      write data
//  mem_ack      in   1       completes the request in the same cycle
//  mem_rdata    in   18      read data, valid in the ack cycle
//  StallM       out  1       hold F/D/E/M; comb
//  RegWriteW, ResultSrcW out 1; RD_W out 5; PCPlus4W, ALU_ResultW, ReadDataW out 18; RGB_W out 2
//  mem_err      out  1       sticky timeout flag
// BEHAVIOUR
//  - Reset: state IDLE; all W outputs 0; mem_err 0. mem_req forced 0 while rst=1.
//    A reset mid-access abandons the access; no write is issued afterwards.
//  - Access = MemWriteM | ResultSrcM. With no access, IDLE passes M to W in 1 cycle and StallM=0.
//  - FSM states: IDLE, RD_WAIT, WR_WAIT, RMW_RD, RMW_WR.
//    IDLE + load -> request issued in the same cycle; ack -> done, else go to RD_WAIT.
//    IDLE + store with RGB=00 -> write; ack -> done, else go to WR_WAIT.
//    IDLE + store with RGB!=00 -> read; ack -> go to RMW_WR, else go to RMW_RD.
//    RMW_RD ack -> capture word, go to RMW_WR. RMW_WR ack -> done.
//    Every WAIT state returns to IDLE on ack.
//  - Bus rule: while mem_req=1 and ack=0, addr/we/wdata stay stable.
//    A zero-wait load or full-word store costs 0 stall cycles; a zero-wait RMW costs 1.
//  - StallM = access & ~done. During a stall, W is loaded with a bubble
//    (RegWriteW=0, other W fields 0). On done, W latches the M fields.
//  - ReadDataW: RGB=00 -> mem_rdata. Otherwise the selected 6-bit field, zero-extended to 18.
//  - RMW write data = captured word with the selected field replaced by WriteDataM[5:0].
//  - Both MemWriteM and ResultSrcM set: treated as a store; ReadDataW=0.
//  - Upper address bits beyond ADDR_W are ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - A cycle counter runs while mem_req=1 & mem_ack=0 and clears on ack or on a new access.
//    - When it reaches TIMEOUT_CYCLES, the access is aborted and treated as done.
//      A pending RMW write is skipped. ReadDataW=18'h3FFFF.
//    - mem_err is set and stays set until rst.
//  Not defined: no counter, the stage waits indefinitely, mem_err is tied 0.
// STRUCTURE
//  - Package proc_mem_pkg: WORD_W=18, CH_W=6, the mem_state_t enum,
//    the RGB_FULL/RGB_R/RGB_G/RGB_B codes.
//  - Sub-module rgb_lane_merge (comb): extracts a zero-extended field from a word
//    and merges a field into a word.
// TESTING
//  1. Zero-wait load, RGB=00, addr 0x005, rdata 0x2ABCD -> no stall; next cycle ReadDataW=0x2ABCD.
//  2. Load with ack delayed 3 cycles -> StallM=1 for 3 cycles, W bubbles, then ReadDataW valid.
//     Bus fields stay stable throughout.
//  3. RGB=10 store of data 0x0003F to a word holding 0x00000, zero-wait -> read then write
//     0x00FC0; StallM=1 for exactly 1 cycle.
//  4. RGB=11 load of word 0x3F000 -> ReadDataW=0x0003F.
//  5. rst asserted in RMW_RD -> next cycle IDLE, W outputs 0, no write ever seen on the bus.
//  6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> abort after 4 wait cycles,
//     ReadDataW=0x3FFFF, mem_err=1 until rst.

Source files
------------

// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the memory-access stage of the 18-bit pipeline.
package proc_mem_pkg;

    localparam int WORD_W = 18;
    localparam int CH_W   = 6;

    localparam logic [1:0] RGB_FULL = 2'b00;
    localparam logic [1:0] RGB_R    = 2'b01;
    localparam logic [1:0] RGB_G    = 2'b10;
    localparam logic [1:0] RGB_B    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RMW_RD,
        RMW_WR
    } mem_state_t;

endpackage

// File: rtl/rgb_lane_merge.sv
// Extracts a zero-extended 6-bit colour channel from a word and merges a channel back into a word.
module rgb_lane_merge
    import proc_mem_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [CH_W-1:0]   field_i,
    input  logic [1:0]        sel_i,
    output logic [WORD_W-1:0] extract_o,
    output logic [WORD_W-1:0] merge_o
);

    // A full-word select leaves the word untouched in both directions.
    always_comb begin
        extract_o = word_i;
        merge_o   = word_i;
        case (sel_i)
            RGB_R: begin
                extract_o                = {{(WORD_W-CH_W){1'b0}}, word_i[CH_W-1:0]};
                merge_o[CH_W-1:0]        = field_i;
            end
            RGB_G: begin
                extract_o                = {{(WORD_W-CH_W){1'b0}}, word_i[2*CH_W-1:CH_W]};
                merge_o[2*CH_W-1:CH_W]   = field_i;
            end
            RGB_B: begin
                extract_o                = {{(WORD_W-CH_W){1'b0}}, word_i[3*CH_W-1:2*CH_W]};
                merge_o[3*CH_W-1:2*CH_W] = field_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// M stage: loads/stores over a req/ack bus with RGB channel read-modify-write, stalls until done.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES wait cycles and sets mem_err.
module memory_access_stage
    import proc_mem_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [WORD_W-1:0] PCPlus4M,
    input  logic [WORD_W-1:0] ALU_ResultM,
    input  logic [WORD_W-1:0] WriteDataM,
    input  logic [1:0]        RGB_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [WORD_W-1:0] PCPlus4W,
    output logic [WORD_W-1:0] ALU_ResultW,
    output logic [WORD_W-1:0] ReadDataW,
    output logic [1:0]        RGB_W,
    output logic              mem_err
);

    mem_state_t        state_q, state_d;
    logic [WORD_W-1:0] capt_q, capt_d;
    logic              regWrite_q, resultSrc_q;
    logic [4:0]        rd_q;
    logic [WORD_W-1:0] pcPlus4_q, aluResult_q, readData_q, readData_d;
    logic [1:0]        rgb_q;

    logic              access, rgbFull, done, abort, reqRaw, weRaw;
    logic [WORD_W-1:0] wdataRaw, laneField, mergedWord;

    assign access   = MemWriteM | ResultSrcM;
    assign rgbFull  = (RGB_M == RGB_FULL);
    assign mem_addr = ALU_ResultM[ADDR_W-1:0];

    rgb_lane_merge u_lane (
        .word_i    (capt_q),
        .field_i   (WriteDataM[CH_W-1:0]),
        .sel_i     (RGB_M),
        .extract_o (),
        .merge_o   (mergedWord)
    );

    rgb_lane_merge u_extract (
        .word_i    (mem_rdata),
        .field_i   (WriteDataM[CH_W-1:0]),
        .sel_i     (RGB_M),
        .extract_o (laneField),
        .merge_o   ()
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeoutHit;

    assign timeoutHit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign mem_err    = err_q;

    logic unusedBits;
    assign unusedBits = ^ALU_ResultM[WORD_W-1:ADDR_W];
`else
    logic timeoutHit;
    assign timeoutHit = 1'b0;
    assign mem_err    = 1'b0;

    logic unusedBits;
    assign unusedBits = ^{ALU_ResultM[WORD_W-1:ADDR_W], TIMEOUT_CYCLES[0]};
`endif

    // Both MemWriteM and ResultSrcM set falls into the store branches.
    always_comb begin
        state_d  = state_q;
        capt_d   = capt_q;
        reqRaw   = 1'b0;
        weRaw    = 1'b0;
        wdataRaw = WriteDataM;
        done     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    reqRaw = 1'b1;
                    if (MemWriteM && rgbFull) begin
                        weRaw = 1'b1;
                        if (mem_ack) done = 1'b1;
                        else         state_d = WR_WAIT;
                    end else if (MemWriteM) begin
                        if (mem_ack) begin
                            capt_d  = mem_rdata;
                            state_d = RMW_WR;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end else begin
                        if (mem_ack) done = 1'b1;
                        else         state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                reqRaw = 1'b1;
                if (mem_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                reqRaw = 1'b1;
                weRaw  = 1'b1;
                if (mem_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            RMW_RD: begin
                reqRaw = 1'b1;
                if (mem_ack) begin
                    capt_d  = mem_rdata;
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                reqRaw   = 1'b1;
                weRaw    = 1'b1;
                wdataRaw = mergedWord;
                if (mem_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An expired wait drops the request, which also skips any pending RMW write.
        if (timeoutHit) begin
            reqRaw  = 1'b0;
            weRaw   = 1'b0;
            done    = 1'b1;
            abort   = 1'b1;
            state_d = IDLE;
        end
    end

    assign mem_req   = reqRaw & ~rst;
    assign mem_we    = weRaw;
    assign mem_wdata = wdataRaw;
    assign StallM    = access & ~done;

    always_comb begin
        readData_d = '0;
        if (abort)
            readData_d = '1;
        else if (ResultSrcM && !MemWriteM)
            readData_d = rgbFull ? mem_rdata : laneField;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            capt_q      <= '0;
            regWrite_q  <= 1'b0;
            resultSrc_q <= 1'b0;
            rd_q        <= '0;
            pcPlus4_q   <= '0;
            aluResult_q <= '0;
            readData_q  <= '0;
            rgb_q       <= '0;
        end else begin
            state_q <= state_d;
            capt_q  <= capt_d;
            if (StallM) begin
                regWrite_q  <= 1'b0;
                resultSrc_q <= 1'b0;
                rd_q        <= '0;
                pcPlus4_q   <= '0;
                aluResult_q <= '0;
                readData_q  <= '0;
                rgb_q       <= '0;
            end else begin
                regWrite_q  <= RegWriteM;
                resultSrc_q <= ResultSrcM;
                rd_q        <= RD_M;
                pcPlus4_q   <= PCPlus4M;
                aluResult_q <= ALU_ResultM;
                readData_q  <= readData_d;
                rgb_q       <= RGB_M;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (done || mem_ack)
                cnt_q <= '0;
            else if (reqRaw)
                cnt_q <= cnt_q + 1'b1;
            if (abort)
                err_q <= 1'b1;
        end
    end
`endif

    assign RegWriteW   = regWrite_q;
    assign ResultSrcW  = resultSrc_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pcPlus4_q;
    assign ALU_ResultW = aluResult_q;
    assign ReadDataW   = readData_q;
    assign RGB_W       = rgb_q;

endmodule
